// File: rtl/dmem_store_buffer.sv
// dmem_store_buffer: in-order store FIFO draining to backing memory, with store-to-load forwarding.
// Optional in-place store coalescing when STBUF_COALESCE_EN is defined.
`default_nettype none

module dmem_store_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 32,
  parameter int DW    = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          memwrite,
  input  logic [AW-1:0] aluout,
  input  logic [DW-1:0] writedata,
  output logic [DW-1:0] readdata,
  output logic          stall,
  output logic [AW-1:0] mem_raddr,
  input  logic [DW-1:0] mem_rdata,
  output logic          mem_wvalid,
  input  logic          mem_wready,
  output logic [AW-1:0] mem_waddr,
  output logic [DW-1:0] mem_wdata,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int WA = AW - 2;

  logic [WA-1:0]    r_addr [DEPTH];
  logic [DW-1:0]    r_data [DEPTH];
  logic [DEPTH-1:0] r_valid;
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [PW:0]      r_count;

  logic          w_full;
  logic          w_pop;
  logic          w_push;
  logic          w_coal;
  logic          w_hit;
  logic [PW-1:0] w_hit_idx;
  logic [DW-1:0] w_fwd_data;

  // Walk entries oldest to youngest so the last match found is the youngest.
  always_comb begin : fwd_search
    logic [PW-1:0] idx;
    w_hit      = 1'b0;
    w_hit_idx  = '0;
    w_fwd_data = mem_rdata;
    idx        = '0;
    for (int i = 0; i < DEPTH; i++) begin
      idx = r_rd_ptr + PW'(i);
      if (r_valid[idx] && (r_addr[idx] == aluout[AW-1:2])) begin
        w_hit      = 1'b1;
        w_hit_idx  = idx;
        w_fwd_data = r_data[idx];
      end
    end
  end

  assign empty  = (r_count == '0);
  assign w_full = (r_count == (PW+1)'(DEPTH));
  assign w_pop  = !empty && mem_wready;

`ifdef STBUF_COALESCE_EN
  // A head entry leaving this cycle cannot absorb the store; allocate instead.
  assign w_coal = memwrite && w_hit && !(w_pop && (w_hit_idx == r_rd_ptr));
  wire w_unused = &{1'b0, aluout[1:0]};
`else
  assign w_coal = 1'b0;
  wire w_unused = &{1'b0, aluout[1:0], w_hit, w_hit_idx};
`endif

  assign stall  = memwrite && w_full && !w_coal;
  assign w_push = memwrite && !w_full && !w_coal;

  assign readdata   = w_fwd_data;
  assign mem_raddr  = aluout;
  assign mem_wvalid = !empty;
  assign mem_waddr  = {r_addr[r_rd_ptr], 2'b00};
  assign mem_wdata  = r_data[r_rd_ptr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_valid  <= '0;
    end else begin
      if (w_push) begin
        r_valid[r_wr_ptr] <= 1'b1;
        r_wr_ptr          <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_valid[r_rd_ptr] <= 1'b0;
        r_rd_ptr          <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Payload storage needs no reset: the valid bits gate every use.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_addr[r_wr_ptr] <= aluout[AW-1:2];
      r_data[r_wr_ptr] <= writedata;
    end else if (w_coal) begin
      r_data[w_hit_idx] <= writedata;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_dmem_store_buffer.sv
// tb_dmem_store_buffer: directed stimulus with a backing-write scoreboard for dmem_store_buffer.
`default_nettype none

module tb_dmem_store_buffer;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          memwrite;
  logic [AW-1:0] aluout;
  logic [DW-1:0] writedata;
  logic [DW-1:0] readdata;
  logic          stall;
  logic [AW-1:0] mem_raddr;
  logic [DW-1:0] mem_rdata;
  logic          mem_wvalid;
  logic          mem_wready;
  logic [AW-1:0] mem_waddr;
  logic [DW-1:0] mem_wdata;
  logic          empty;

  int n_cmp = 0;
  int n_bad = 0;

  logic [AW+DW-1:0] exp_q [$];

  dmem_store_buffer #(.DEPTH(4), .AW(AW), .DW(DW)) dut (
    .clk(clk), .reset(reset), .memwrite(memwrite), .aluout(aluout),
    .writedata(writedata), .readdata(readdata), .stall(stall),
    .mem_raddr(mem_raddr), .mem_rdata(mem_rdata), .mem_wvalid(mem_wvalid),
    .mem_wready(mem_wready), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata),
    .empty(empty)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [AW-1:0] a, input logic [DW-1:0] d, input bit expect_write);
    memwrite  = 1'b1;
    aluout    = a;
    writedata = d;
    if (expect_write) exp_q.push_back({a & ~32'h3, d});
    tick();
    memwrite = 1'b0;
  endtask

  task automatic wait_empty(input string name);
    int cyc = 0;
    while (!empty && cyc < 30) begin
      tick();
      cyc++;
    end
    check(name, {63'd0, empty}, 64'd1);
    check({name, "_q"}, 64'(exp_q.size()), 64'd0);
  endtask

  // Backing-write monitor: each handshake seen here completes on the next rising edge.
  initial begin
    logic [AW+DW-1:0] e;
    forever begin
      @(negedge clk);
      if (mem_wvalid && mem_wready) begin
        if (exp_q.size() == 0) begin
          check("unexpected_write", {mem_waddr, mem_wdata}, 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          e = exp_q.pop_front();
          check("wr_addr", 64'(mem_waddr), 64'(e[AW+DW-1:DW]));
          check("wr_data", 64'(mem_wdata), 64'(e[DW-1:0]));
        end
      end
    end
  end

  initial begin
    reset = 1'b1; memwrite = 1'b0; aluout = '0; writedata = '0;
    mem_rdata = 32'h5A5A; mem_wready = 1'b0;
    #12;
    check("rst_wvalid", {63'd0, mem_wvalid}, 64'd0);
    check("rst_empty", {63'd0, empty}, 64'd1);
    check("rst_stall", {63'd0, stall}, 64'd0);
    check("rst_readdata", 64'(readdata), 64'h5A5A);
    tick();
    reset = 1'b0;

    // single store then one-cycle drain
    store(32'd100, 32'd25, 1'b1);
    #1;
    check("t1_wvalid", {63'd0, mem_wvalid}, 64'd1);
    check("t1_waddr", 64'(mem_waddr), 64'd100);
    check("t1_wdata", 64'(mem_wdata), 64'd25);
    check("t1_empty", {63'd0, empty}, 64'd0);
    mem_wready = 1'b1;
    tick();
    mem_wready = 1'b0;
    #1;
    check("t1_empty_after", {63'd0, empty}, 64'd1);

    // fill, stall, then drain in order
    store(32'h0, 32'h11, 1'b1);
    store(32'h4, 32'h22, 1'b1);
    store(32'h8, 32'h33, 1'b1);
    store(32'hC, 32'h44, 1'b1);
    memwrite = 1'b1; aluout = 32'h10; writedata = 32'h55;
    #1;
    check("t2_full_stall", {63'd0, stall}, 64'd1);
    tick();
    mem_wready = 1'b1;
    #1;
    check("t2_stall_with_pop", {63'd0, stall}, 64'd1);
    tick();
    exp_q.push_back({32'h10, 32'h55});
    check("t2_accept_after_pop", {63'd0, stall}, 64'd0);
    tick();
    memwrite = 1'b0;
    wait_empty("t2_drain");

    // forwarding
    mem_wready = 1'b0;
`ifdef STBUF_COALESCE_EN
    store(32'd100, 32'hA, 1'b0);
    store(32'd100, 32'hB, 1'b1);
`else
    store(32'd100, 32'hA, 1'b1);
    store(32'd100, 32'hB, 1'b1);
`endif
    aluout = 32'd102; mem_rdata = 32'hDEAD;
    #1;
    check("t3_fwd_youngest", 64'(readdata), 64'hB);
    aluout = 32'd200; mem_rdata = 32'h1234;
    #1;
    check("t3_no_match", 64'(readdata), 64'h1234);
    check("t3_raddr", 64'(mem_raddr), 64'd200);
    aluout = 32'd100; mem_rdata = 32'hDEAD; mem_wready = 1'b1;
    #1;
    check("t3_fwd_while_pop", 64'(readdata), 64'hB);
`ifndef STBUF_COALESCE_EN
    tick();
    check("t3_fwd_head_pop", 64'(readdata), 64'hB);
`endif
    tick();
    check("t3_after_drain", 64'(readdata), 64'hDEAD);
    wait_empty("t3_drain");

    // full with memwrite held and wready high: one accept per cycle after first pop
    mem_wready = 1'b0;
    for (int k = 0; k < 4; k++) store(32'h200 + 32'(4*k), 32'h100 + 32'(k), 1'b1);
    for (int k = 4; k < 8; k++) exp_q.push_back({32'h200 + 32'(4*k), 32'h100 + 32'(k)});
    mem_wready = 1'b1;
    memwrite = 1'b1; aluout = 32'h210; writedata = 32'h104;
    #1;
    check("t4_first_stall", {63'd0, stall}, 64'd1);
    tick();
    for (int k = 4; k < 8; k++) begin
      aluout = 32'h200 + 32'(4*k); writedata = 32'h100 + 32'(k);
      #1;
      check("t4_no_stall", {63'd0, stall}, 64'd0);
      tick();
    end
    memwrite = 1'b0;
    wait_empty("t4_drain");

    // reset with pending stores discards them
    mem_wready = 1'b0;
    store(32'h300, 32'h1, 1'b0);
    store(32'h304, 32'h2, 1'b0);
    store(32'h308, 32'h3, 1'b0);
    #1;
    check("t5_pending", {63'd0, mem_wvalid}, 64'd1);
    #1;
    reset = 1'b1;
    #1;
    check("t5_rst_wvalid", {63'd0, mem_wvalid}, 64'd0);
    check("t5_rst_empty", {63'd0, empty}, 64'd1);
    tick();
    reset = 1'b0;
    mem_wready = 1'b1;
    repeat (10) tick();
    check("t5_still_empty", {63'd0, empty}, 64'd1);
    check("t5_q", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
